// File: rtl/vslc_pkg.sv
// vslc_pkg: shared types for the VSLC serial I/O scanner.
//   scan_state_t : scanner FSM states (IDLE, LOAD, SHIFT, LATCH)
//   SCAN_STATE_W : width of the state encoding
//   max_u()      : elaboration-time max used to size the shift chain
package vslc_pkg;

  localparam int unsigned SCAN_STATE_W = 2;

  typedef enum logic [SCAN_STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } scan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vslc_scan_tick.sv
// vslc_scan_tick: bit-period phase generator for the serial scanner.
// A bit period is 2*CLK_DIV clocks: a low half then a high half of CLK_DIV
// clocks each. The counter is held at the start of a low half while en_i=0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en_i              : run the phase counter
//   phase_hi_o        : 1 during the high half of the bit period
//   phase_lo_first_o  : first clock of a low half
//   phase_lo_last_o   : last clock of a low half
//   half_end_o        : last clock of either half
module vslc_scan_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic phase_hi_o,
  output logic phase_lo_first_o,
  output logic phase_lo_last_o,
  output logic half_end_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_hi_o       = phase_q;
  assign half_end_o       = en_i && (cnt_q == LAST);
  assign phase_lo_first_o = en_i && !phase_q && (cnt_q == '0);
  assign phase_lo_last_o  = en_i && !phase_q && (cnt_q == LAST);

endmodule

// File: rtl/vslc_io_scanner.sv
// vslc_io_scanner: host-side serial I/O expander (74HC165 in, 74HC595 out).
// Each scan: parallel-load the 165 chain, shift NB=max(N_IN,N_OUT) bits in
// and out, then pulse the 595 storage clock. done pulses in the last clock
// of the scan; in_data presents the new image from that clock on.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : scan request (accepted only in IDLE)
//   out_data   : output image, captured when a scan is accepted
//   busy, done : scan in progress / 1-cycle completion pulse
//   in_data    : input image from the 165 chain
//   sr_clk, sr_load_n, sr_latch, sr_dout : chain control and serial out
//   sr_din     : serial in from 165 QH (already synchronised)
// Build option: VSLC_SCAN_AUTO_EN makes the scanner rescan continuously and
// ignore start.
module vslc_io_scanner
  import vslc_pkg::*;
#(
  parameter int unsigned N_IN    = 8,
  parameter int unsigned N_OUT   = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  in_data,
  output logic             sr_clk,
  output logic             sr_load_n,
  output logic             sr_latch,
  output logic             sr_dout,
  input  logic             sr_din
);

  localparam int unsigned     NB    = max_u(N_IN, N_OUT);
  localparam int unsigned     CNT_W = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] NB_C = CNT_W'(NB);
  localparam logic [CNT_W-1:0] IN_C = CNT_W'(N_IN);

  scan_state_t      state_q, state_d;
  logic [NB-1:0]    out_sr_q, out_sr_d;
  logic [N_IN-1:0]  in_sr_q, in_sr_d;
  logic [N_IN-1:0]  in_data_q, in_data_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;

  logic go;
  logic phase_hi, lo_last, half_end, bp_end;
  logic unused_lo_first;

`ifdef VSLC_SCAN_AUTO_EN
  logic unused_start;
  assign unused_start = start;
  assign go           = 1'b1;
`else
  assign go = start;
`endif

  vslc_scan_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk              (clk),
    .rst              (rst),
    .en_i             (state_q != IDLE),
    .phase_hi_o       (phase_hi),
    .phase_lo_first_o (unused_lo_first),
    .phase_lo_last_o  (lo_last),
    .half_end_o       (half_end)
  );

  assign bp_end = half_end && phase_hi;

  // sr_dout is registered and reloaded at the end of each bit period so the
  // new bit appears exactly on the first clock of the next low half.
  always_comb begin
    state_d   = state_q;
    out_sr_d  = out_sr_q;
    in_sr_d   = in_sr_q;
    in_data_d = in_data_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = dout_q;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          out_sr_d  = NB'(out_data);
          bit_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (bp_end) begin
          dout_d   = out_sr_q[NB-1];
          out_sr_d = out_sr_q << 1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (lo_last && (bit_cnt_q < IN_C)) begin
          in_sr_d = (in_sr_q << 1) | N_IN'(sr_din);
        end
        if (bp_end) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_d == NB_C) begin
            state_d = LATCH;
          end else begin
            dout_d   = out_sr_q[NB-1];
            out_sr_d = out_sr_q << 1;
          end
        end
      end
      LATCH: begin
        if (bp_end) begin
          done      = 1'b1;
          in_data_d = in_sr_q;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_sr_q  <= '0;
      in_sr_q   <= '0;
      in_data_q <= '0;
      bit_cnt_q <= '0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_sr_q  <= out_sr_d;
      in_sr_q   <= in_sr_d;
      in_data_q <= in_data_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
    end
  end

  // Bypass so the fresh image is visible in the done cycle itself.
  assign in_data   = done ? in_sr_q : in_data_q;
  assign busy      = (state_q != IDLE);
  assign sr_clk    = (state_q == SHIFT) && phase_hi;
  assign sr_load_n = (state_q != LOAD);
  assign sr_latch  = (state_q == LATCH) && !phase_hi;
  assign sr_dout   = dout_q;

endmodule
